// File: rtl/dbg_mem_pkg.sv
// Shared types for the debug memory controller.
// FSM states, decode regions and the word size.
package dbg_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        REG_IMEM,
        REG_DMEM,
        REG_NONE
    } region_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dbg_mem_ctrl_if.sv
// Host request/response channel of the debug memory controller.
// master: host transport side; slave: dbg_mem_ctrl.
interface dbg_mem_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid,
        input  req_ready,
        output req_we,
        output req_addr,
        output req_wdata,
        output req_wstrb,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  req_wstrb,
        output rsp_valid,
        input  rsp_ready,
        output rsp_rdata,
        output rsp_err
    );

endinterface

// File: rtl/dbg_addr_decode.sv
// Byte address to IMEM/DMEM window decode (combinational).
// In: req_addr. Out: region, per-window word index, err.
module dbg_addr_decode
    import dbg_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH_I = 10,
    parameter int          ADDR_WIDTH_D = 10,
    parameter logic [31:0] IMEM_BASE    = 32'h0000_0000,
    parameter logic [31:0] DMEM_BASE    = 32'h1000_0000
) (
    input  logic [31:0]             req_addr,
    output region_t                 region,
    output logic [ADDR_WIDTH_I-1:0] idx_i,
    output logic [ADDR_WIDTH_D-1:0] idx_d,
    output logic                    err
);

    // Window sizes in bytes; 33 bits so a full 4 GiB span cannot overflow.
    localparam logic [32:0] SPAN_I = 33'(WORD_BYTES) << ADDR_WIDTH_I;
    localparam logic [32:0] SPAN_D = 33'(WORD_BYTES) << ADDR_WIDTH_D;

    logic [31:0] off_i;
    logic [31:0] off_d;
    logic        hit_i;
    logic        hit_d;

    // Offsets wrap in 32 bits, so an address below a base looks huge
    // and falls out of that window.
    assign off_i = req_addr - IMEM_BASE;
    assign off_d = req_addr - DMEM_BASE;
    assign hit_i = {1'b0, off_i} < SPAN_I;
    assign hit_d = {1'b0, off_d} < SPAN_D;
    assign idx_i = off_i[ADDR_WIDTH_I+1:2];
    assign idx_d = off_d[ADDR_WIDTH_D+1:2];

    // IMEM takes priority when the windows overlap.
    always_comb begin
        region = REG_NONE;
        if (hit_i) begin
            region = REG_IMEM;
        end else if (hit_d) begin
            region = REG_DMEM;
        end
    end

    assign err = (req_addr[1:0] != 2'b00) || (region == REG_NONE);

endmodule

// File: rtl/dbg_mem_ctrl.sv
// Debug/loader controller driving Port B of IMEM and DMEM.
// Ports: clk, rst_n, bus (request/response slave), imem_b_* and
// dmem_b_* memory Port B groups, hold_req in, cpu_rst_n out.
// Optional macro DBG_MEM_CTRL_CPU_HOLD_EN: hold_req holds cpu_rst_n low.
module dbg_mem_ctrl
    import dbg_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH_I = 10,
    parameter int          DATA_WIDTH_I = 32,
    parameter int          ADDR_WIDTH_D = 10,
    parameter int          DATA_WIDTH_D = 32,
    parameter logic [31:0] IMEM_BASE    = 32'h0000_0000,
    parameter logic [31:0] DMEM_BASE    = 32'h1000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dbg_mem_ctrl_if.slave           bus,

    output logic                    imem_b_en,
    output logic                    imem_b_we,
    output logic [3:0]              imem_b_wstrb,
    output logic [ADDR_WIDTH_I-1:0] imem_b_addr,
    output logic [DATA_WIDTH_I-1:0] imem_b_wdata,
    input  logic [DATA_WIDTH_I-1:0] imem_b_rdata,

    output logic                    dmem_b_en,
    output logic                    dmem_b_we,
    output logic [3:0]              dmem_b_wstrb,
    output logic [ADDR_WIDTH_D-1:0] dmem_b_addr,
    output logic [DATA_WIDTH_D-1:0] dmem_b_wdata,
    input  logic [DATA_WIDTH_D-1:0] dmem_b_rdata,

    input  logic                    hold_req,
    output logic                    cpu_rst_n
);

    state_t                  state_q, state_d;
    region_t                 region_q, region_d;
    logic                    we_q, we_d;

    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic                    imem_en_d, imem_we_d;
    logic [3:0]              imem_wstrb_d;
    logic [ADDR_WIDTH_I-1:0] imem_addr_d;
    logic [DATA_WIDTH_I-1:0] imem_wdata_d;

    logic                    dmem_en_d, dmem_we_d;
    logic [3:0]              dmem_wstrb_d;
    logic [ADDR_WIDTH_D-1:0] dmem_addr_d;
    logic [DATA_WIDTH_D-1:0] dmem_wdata_d;

    region_t                 dec_region;
    logic [ADDR_WIDTH_I-1:0] dec_idx_i;
    logic [ADDR_WIDTH_D-1:0] dec_idx_d;
    logic                    dec_err;
    logic                    accept;

    dbg_addr_decode #(
        .ADDR_WIDTH_I (ADDR_WIDTH_I),
        .ADDR_WIDTH_D (ADDR_WIDTH_D),
        .IMEM_BASE    (IMEM_BASE),
        .DMEM_BASE    (DMEM_BASE)
    ) u_dec (
        .req_addr (bus.req_addr),
        .region   (dec_region),
        .idx_i    (dec_idx_i),
        .idx_d    (dec_idx_d),
        .err      (dec_err)
    );

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    assign accept = bus.req_valid && req_ready_q;

    // Port B registers are loaded on the accept edge so the enable
    // is visible during ISSUE and cleared on the following edge.
    always_comb begin
        state_d      = state_q;
        region_d     = region_q;
        we_d         = we_q;
        req_ready_d  = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        imem_en_d    = 1'b0;
        imem_we_d    = 1'b0;
        imem_wstrb_d = '0;
        imem_addr_d  = '0;
        imem_wdata_d = '0;
        dmem_en_d    = 1'b0;
        dmem_we_d    = 1'b0;
        dmem_wstrb_d = '0;
        dmem_addr_d  = '0;
        dmem_wdata_d = '0;

        unique case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    req_ready_d = 1'b0;
                    we_d        = bus.req_we;
                    region_d    = dec_region;
                    rsp_rdata_d = '0;
                    rsp_err_d   = dec_err;
                    if (dec_err) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        if (dec_region == REG_IMEM) begin
                            imem_en_d    = 1'b1;
                            imem_we_d    = bus.req_we;
                            imem_wstrb_d = bus.req_we ? bus.req_wstrb : 4'h0;
                            imem_addr_d  = dec_idx_i;
                            imem_wdata_d = bus.req_wdata;
                        end else begin
                            dmem_en_d    = 1'b1;
                            dmem_we_d    = bus.req_we;
                            dmem_wstrb_d = bus.req_we ? bus.req_wstrb : 4'h0;
                            dmem_addr_d  = dec_idx_d;
                            dmem_wdata_d = bus.req_wdata;
                        end
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Memory read data is valid one cycle after the enable.
                rsp_rdata_d = (region_q == REG_DMEM) ? dmem_b_rdata
                                                     : imem_b_rdata;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            region_q     <= REG_NONE;
            we_q         <= 1'b0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            imem_b_en    <= 1'b0;
            imem_b_we    <= 1'b0;
            imem_b_wstrb <= '0;
            imem_b_addr  <= '0;
            imem_b_wdata <= '0;
            dmem_b_en    <= 1'b0;
            dmem_b_we    <= 1'b0;
            dmem_b_wstrb <= '0;
            dmem_b_addr  <= '0;
            dmem_b_wdata <= '0;
        end else begin
            state_q      <= state_d;
            region_q     <= region_d;
            we_q         <= we_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            imem_b_en    <= imem_en_d;
            imem_b_we    <= imem_we_d;
            imem_b_wstrb <= imem_wstrb_d;
            imem_b_addr  <= imem_addr_d;
            imem_b_wdata <= imem_wdata_d;
            dmem_b_en    <= dmem_en_d;
            dmem_b_we    <= dmem_we_d;
            dmem_b_wstrb <= dmem_wstrb_d;
            dmem_b_addr  <= dmem_addr_d;
            dmem_b_wdata <= dmem_wdata_d;
        end
    end

`ifdef DBG_MEM_CTRL_CPU_HOLD_EN
    // hold_q resets high so the CPU stays in reset until the host
    // has been seen releasing hold_req.
    logic hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= 1'b1;
            cpu_rst_n <= 1'b0;
        end else begin
            hold_q    <= hold_req;
            cpu_rst_n <= !hold_q;
        end
    end
`else
    logic unused_hold_req;

    assign unused_hold_req = hold_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rst_n <= 1'b0;
        end else begin
            cpu_rst_n <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dbg_mem_ctrl.sv
// Directed self-checking bench for dbg_mem_ctrl.
// Small IMEM/DMEM models with byte strobes sit on Port B.
module tb_dbg_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        hold_req;
    logic        imem_b_en, imem_b_we;
    logic [3:0]  imem_b_wstrb;
    logic [9:0]  imem_b_addr;
    logic [31:0] imem_b_wdata, imem_b_rdata;
    logic        dmem_b_en, dmem_b_we;
    logic [3:0]  dmem_b_wstrb;
    logic [9:0]  dmem_b_addr;
    logic [31:0] dmem_b_wdata, dmem_b_rdata;
    logic        cpu_rst_n;

    int n_tests;
    int n_fail;
    int unsigned dmem_en_cnt;

    logic [31:0] imem [1024];
    logic [31:0] dmem [1024];

    dbg_mem_ctrl_if bus();

    dbg_mem_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .imem_b_en    (imem_b_en),
        .imem_b_we    (imem_b_we),
        .imem_b_wstrb (imem_b_wstrb),
        .imem_b_addr  (imem_b_addr),
        .imem_b_wdata (imem_b_wdata),
        .imem_b_rdata (imem_b_rdata),
        .dmem_b_en    (dmem_b_en),
        .dmem_b_we    (dmem_b_we),
        .dmem_b_wstrb (dmem_b_wstrb),
        .dmem_b_addr  (dmem_b_addr),
        .dmem_b_wdata (dmem_b_wdata),
        .dmem_b_rdata (dmem_b_rdata),
        .hold_req     (hold_req),
        .cpu_rst_n    (cpu_rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_b_en) begin
            if (imem_b_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (imem_b_wstrb[b]) begin
                        imem[imem_b_addr][8*b +: 8] <= imem_b_wdata[8*b +: 8];
                    end
                end
            end
            imem_b_rdata <= imem[imem_b_addr];
        end
    end

    always @(posedge clk) begin
        if (dmem_b_en) begin
            dmem_en_cnt <= dmem_en_cnt + 1;
            if (dmem_b_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (dmem_b_wstrb[b]) begin
                        dmem[dmem_b_addr][8*b +: 8] <= dmem_b_wdata[8*b +: 8];
                    end
                end
            end
            dmem_b_rdata <= dmem[dmem_b_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request; returns at cycle N+1 (+1ns) when accepted.
    task automatic send_req(
        input  logic        we,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [3:0]  wstrb,
        output bit          ok
    );
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = wstrb;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 ||
            bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp: ready=%b valid=%b rdata=%h err=%b want 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        n_tests++;
        if (imem_b_en !== 1'b0 || dmem_b_en !== 1'b0 ||
            dmem_b_addr !== 10'h0 || imem_b_wdata !== 32'h0 ||
            cpu_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_port: ien=%b den=%b daddr=%h cpu_rst_n=%b want 0",
                     imem_b_en, dmem_b_en, dmem_b_addr, cpu_rst_n);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", bus.req_ready);
        end
        n_tests++;
`ifdef DBG_MEM_CTRL_CPU_HOLD_EN
        if (cpu_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_rst_first: got %b want 0", cpu_rst_n);
        end
`else
        if (cpu_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL cpu_rst_first: got %b want 1", cpu_rst_n);
        end
`endif
        tick();
        n_tests++;
        if (cpu_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL cpu_rst_second: got %b want 1", cpu_rst_n);
        end
    endtask

    task automatic test_write_dmem();
        bit ok;
        send_req(1'b1, 32'h1000_0008, 32'hDEAD_BEEF, 4'hF, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wr_accept: got timeout want accept");
        end
        n_tests++;
        if (dmem_b_en !== 1'b1 || dmem_b_we !== 1'b1 ||
            dmem_b_addr !== 10'd2 || dmem_b_wdata !== 32'hDEAD_BEEF ||
            dmem_b_wstrb !== 4'hF || imem_b_en !== 1'b0 ||
            bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_issue: en=%b we=%b addr=%0d wd=%h st=%h ien=%b v=%b",
                     dmem_b_en, dmem_b_we, dmem_b_addr, dmem_b_wdata,
                     dmem_b_wstrb, imem_b_en, bus.rsp_valid);
        end
        tick();
        n_tests++;
        if (dmem_b_en !== 1'b0 || imem_b_en !== 1'b0 ||
            bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0 ||
            bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_resp: den=%b v=%b rd=%h err=%b want 0 1 0 0",
                     dmem_b_en, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        n_tests++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_done: valid=%b ready=%b want 0 1",
                     bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_read_dmem();
        bit ok;
        send_req(1'b0, 32'h1000_0008, 32'h0, 4'hF, ok);
        n_tests++;
        if (!ok || dmem_b_en !== 1'b1 || dmem_b_we !== 1'b0 ||
            dmem_b_wstrb !== 4'h0 || dmem_b_addr !== 10'd2) begin
            n_fail++;
            $display("FAIL rd_issue: ok=%b en=%b we=%b st=%h addr=%0d",
                     ok, dmem_b_en, dmem_b_we, dmem_b_wstrb, dmem_b_addr);
        end
        tick();
        n_tests++;
        if (bus.rsp_valid !== 1'b0 || dmem_b_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_wait: valid=%b en=%b want 0 0",
                     bus.rsp_valid, dmem_b_en);
        end
        tick();
        n_tests++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEAD_BEEF ||
            bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_resp: valid=%b rdata=%h err=%b want 1 deadbeef 0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_imem_boundary();
        bit ok;
        send_req(1'b1, 32'h0000_0FFC, 32'hA5A5_1234, 4'hF, ok);
        n_tests++;
        if (!ok || imem_b_en !== 1'b1 || imem_b_addr !== 10'd1023 ||
            dmem_b_en !== 1'b0) begin
            n_fail++;
            $display("FAIL imem_top_wr: ok=%b ien=%b addr=%0d den=%b want 1 1 1023 0",
                     ok, imem_b_en, imem_b_addr, dmem_b_en);
        end
        tick();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        send_req(1'b0, 32'h0000_0FFC, 32'h0, 4'h0, ok);
        n_tests++;
        if (!ok || imem_b_en !== 1'b1 || imem_b_addr !== 10'd1023) begin
            n_fail++;
            $display("FAIL imem_top_rd: ok=%b en=%b addr=%0d want 1 1 1023",
                     ok, imem_b_en, imem_b_addr);
        end
        repeat (2) tick();
        n_tests++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hA5A5_1234) begin
            n_fail++;
            $display("FAIL imem_top_data: valid=%b rdata=%h want 1 a5a51234",
                     bus.rsp_valid, bus.rsp_rdata);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        send_req(1'b0, 32'h0000_1000, 32'h0, 4'h0, ok);
        n_tests++;
        if (!ok || bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 ||
            bus.rsp_rdata !== 32'h0 || imem_b_en !== 1'b0 ||
            dmem_b_en !== 1'b0) begin
            n_fail++;
            $display("FAIL imem_past_end: v=%b err=%b rd=%h ien=%b den=%b",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata,
                     imem_b_en, dmem_b_en);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_errors();
        bit ok;
        logic [31:0] addrs [2];
        addrs[0] = 32'h1000_0002;
        addrs[1] = 32'h0FFF_FFFC;
        for (int k = 0; k < 2; k++) begin
            send_req(1'b0, addrs[k], 32'h0, 4'h0, ok);
            n_tests++;
            if (!ok || bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 ||
                bus.rsp_rdata !== 32'h0 || imem_b_en !== 1'b0 ||
                dmem_b_en !== 1'b0) begin
                n_fail++;
                $display("FAIL err_%h: v=%b err=%b rd=%h ien=%b den=%b",
                         addrs[k], bus.rsp_valid, bus.rsp_err,
                         bus.rsp_rdata, imem_b_en, dmem_b_en);
            end
            tick();
            n_tests++;
            if (imem_b_en !== 1'b0 || dmem_b_en !== 1'b0 ||
                bus.rsp_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL err_hold_%h: ien=%b den=%b v=%b want 0 0 1",
                         addrs[k], imem_b_en, dmem_b_en, bus.rsp_valid);
            end
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
        end
    endtask

    task automatic test_strobes();
        bit ok;
        send_req(1'b1, 32'h1000_0008, 32'h1111_1111, 4'h0, ok);
        n_tests++;
        if (!ok || dmem_b_en !== 1'b1 || dmem_b_wstrb !== 4'h0) begin
            n_fail++;
            $display("FAIL zero_strb_issue: ok=%b en=%b st=%h want 1 1 0",
                     ok, dmem_b_en, dmem_b_wstrb);
        end
        tick();
        n_tests++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_strb_resp: v=%b err=%b want 1 0",
                     bus.rsp_valid, bus.rsp_err);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        send_req(1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, ok);
        tick();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        send_req(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'h3, ok);
        tick();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        send_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, ok);
        repeat (2) tick();
        n_tests++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h1234_F00D) begin
            n_fail++;
            $display("FAIL part_strb: v=%b rdata=%h want 1 1234f00d",
                     bus.rsp_valid, bus.rsp_rdata);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        send_req(1'b0, 32'h1000_0008, 32'h0, 4'h0, ok);
        repeat (2) tick();
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEAD_BEEF ||
                bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_%0d: v=%b rd=%h rdy=%b want 1 deadbeef 0",
                         c, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        send_req(1'b0, 32'h0000_0FFC, 32'h0, 4'h0, ok);
        n_tests++;
        if (!ok || imem_b_en !== 1'b1) begin
            n_fail++;
            $display("FAIL next_accept: ok=%b ien=%b want 1 1", ok, imem_b_en);
        end
        repeat (2) tick();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        // Early rsp_ready: must not shortcut the read latency.
        bus.rsp_ready = 1'b1;
        send_req(1'b0, 32'h1000_0008, 32'h0, 4'h0, ok);
        tick();
        n_tests++;
        if (bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL early_ready_n2: valid=%b want 0", bus.rsp_valid);
        end
        tick();
        n_tests++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL early_ready_n3: v=%b rd=%h want 1 deadbeef",
                     bus.rsp_valid, bus.rsp_rdata);
        end
        tick();
        bus.rsp_ready = 1'b0;
        n_tests++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL early_ready_n4: v=%b rdy=%b want 0 1",
                     bus.rsp_valid, bus.req_ready);
        end
    endtask

`ifdef DBG_MEM_CTRL_CPU_HOLD_EN
    task automatic test_cpu_hold();
        bit ok;
        hold_req = 1'b1;
        repeat (3) tick();
        send_req(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'hF, ok);
        tick();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        n_tests++;
        if (cpu_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_active: cpu_rst_n=%b want 0", cpu_rst_n);
        end
        hold_req = 1'b0;
        tick();
        n_tests++;
        if (cpu_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_rel_1: cpu_rst_n=%b want 0", cpu_rst_n);
        end
        tick();
        n_tests++;
        if (cpu_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_rel_2: cpu_rst_n=%b want 1", cpu_rst_n);
        end
    endtask
`endif

    task automatic test_reset_mid_issue();
        bit ok;
        int unsigned cnt0;
        cnt0 = dmem_en_cnt;
        send_req(1'b1, 32'h1000_0020, 32'h5555_5555, 4'hF, ok);
        n_tests++;
        if (!ok || dmem_b_en !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_issue_en: ok=%b en=%b want 1 1", ok, dmem_b_en);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (dmem_b_en !== 1'b0 || dmem_b_we !== 1'b0 ||
            imem_b_en !== 1'b0 || bus.req_ready !== 1'b0 ||
            bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_issue_rst: den=%b dwe=%b ien=%b rdy=%b v=%b",
                     dmem_b_en, dmem_b_we, imem_b_en, bus.req_ready,
                     bus.rsp_valid);
        end
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        n_tests++;
        if (dmem_en_cnt !== cnt0 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_issue_after: en_cnt=%0d want %0d v=%b",
                     dmem_en_cnt, cnt0, bus.rsp_valid);
        end
        send_req(1'b0, 32'h1000_0008, 32'h0, 4'h0, ok);
        repeat (2) tick();
        n_tests++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL post_rst_rd: v=%b rd=%h want 1 deadbeef",
                     bus.rsp_valid, bus.rsp_rdata);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        hold_req      = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_write_dmem();
        test_read_dmem();
        test_imem_boundary();
        test_errors();
        test_strobes();
        test_back_to_back();
`ifdef DBG_MEM_CTRL_CPU_HOLD_EN
        test_cpu_hold();
`endif
        test_reset_mid_issue();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dbg_mem_ctrl.md
Name: dbg_mem_ctrl

Overview:
- Debug/loader controller that sequences the Port B (debug/DMA) side of the IMEM and DMEM macros.
- Accepts single-word requests on a valid/ready channel carrying a 32-bit byte address.
- Decodes each request to IMEM or DMEM, drives the selected memory's Port B for one cycle and absorbs the 1-cycle synchronous read latency.
- Returns read data or an error on a valid/ready response channel; sits between a host-side transport (UART/JTAG/bus bridge) and the SoC top.

Parameters:
- ADDR_WIDTH_I, 10, IMEM word-address width.
- DATA_WIDTH_I, 32, IMEM data width.
- ADDR_WIDTH_D, 10, DMEM word-address width.
- DATA_WIDTH_D, 32, DMEM data width; must equal DATA_WIDTH_I.
- IMEM_BASE, 32'h0000_0000, byte base address of the IMEM window.
- DMEM_BASE, 32'h1000_0000, byte base address of the DMEM window.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_wstrb  in  4  byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  decode or alignment error
- imem_b_en / imem_b_we  out  1 each  IMEM Port B controls
- imem_b_wstrb  out  4  IMEM Port B strobes
- imem_b_addr  out  ADDR_WIDTH_I  IMEM Port B word address
- imem_b_wdata  out  32  IMEM Port B write data
- imem_b_rdata  in  32  IMEM Port B read data
- dmem_b_en / dmem_b_we / dmem_b_wstrb / dmem_b_addr / dmem_b_wdata  out  same widths as the IMEM group, using ADDR_WIDTH_D  DMEM Port B controls
- dmem_b_rdata  in  32  DMEM Port B read data
- hold_req  in  1  host request to hold the CPU
- cpu_rst_n  out  1  reset for the CPU core (AND-ed with rst_n at SoC top)

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, all *_b_en/_we/_wstrb/_addr/_wdata=0, cpu_rst_n=0, state=IDLE.
- Decode (combinational on req_addr):
  - IMEM hit when IMEM_BASE <= addr < IMEM_BASE + 4*2**ADDR_WIDTH_I.
  - DMEM hit likewise with DMEM_BASE and ADDR_WIDTH_D.
  - Word index = (addr - base) >> 2, truncated to the port width.
  - Error when addr[1:0] != 0 or neither window hits.
  - If the windows overlap, IMEM wins.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On accept (cycle N): latch we/region/index/wdata/wstrb/err.
  - If err → RESP with rsp_err=1; rsp_valid is high from N+1; no memory enable.
  - Else → ISSUE.
- ISSUE (N+1):
  - Selected port: en=1, we=req_we, wstrb=req_we ? req_wstrb : 0, addr=index, wdata.
  - Non-selected port: all zero. Asserted for exactly one cycle.
  - Write → RESP (rsp_valid high from N+2, rdata=0).
  - Read → WAIT.
- WAIT (N+2):
  - Capture the selected port's rdata into rsp_rdata.
  - → RESP; rsp_valid high from N+3.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready.
  - On the handshake → IDLE; rsp_valid drops the next cycle.
  - req_ready stays 0 everywhere except IDLE, so at most one transaction is outstanding.
- rsp_ready high before rsp_valid has no effect.
- req_wstrb=0 on a write: the port is still enabled with no bytes written, and a normal response is returned.
- Address wrap: addr - base is computed in 32 bits; wrap below base fails the range check and flags an error.
- Reset mid-transaction: asynchronous return to the reset values; no partial write is issued after reset deasserts.
- cpu_rst_n behaviour is defined under Optional Feature.

Optional Feature:
- Macro: DBG_MEM_CTRL_CPU_HOLD_EN.
- Defined:
  - cpu_rst_n = registered !hold_q, where hold_q follows hold_req with one flop.
  - cpu_rst_n=0 from reset until hold_req has been sampled low.
  - Deasserting hold_req releases the CPU 2 cycles later.
  - While hold_q=1, cpu_rst_n=0 regardless of transaction state.
- Not defined: cpu_rst_n is a flop that goes to 1 on the first clock after reset release; hold_req is ignored.

Decomposition:
- Package dbg_mem_pkg:
  - state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - region_t enum {REG_IMEM, REG_DMEM, REG_NONE}.
  - WORD_BYTES=4 constant.
- Sub-module dbg_addr_decode: combinational; inputs req_addr; outputs region_t, word index and err; parameterised on the bases and widths.

Test Plan:
- Write 0x1000_0008, wdata 0xDEADBEEF, wstrb 4'hF → dmem_b_en=1 for one cycle at N+1 with addr=2; rsp_valid at N+2 with rdata=0, err=0; imem_b_en stays 0.
- Read 0x1000_0008 after that write → dmem_b_en at N+1; rsp_valid at N+3 with rdata=0xDEADBEEF.
- Read 0x0000_0FFC and 0x0000_1000 → first gives IMEM addr=1023; second gives rsp_err=1 at N+1, no en on either port.
- Misaligned read 0x1000_0002 → rsp_err=1, rdata=0, no port activity.
- Hold rsp_ready=0 for 5 cycles → rsp_valid/rdata stable and req_ready=0 throughout; handshake → IDLE, next request accepted.
- DBG_MEM_CTRL_CPU_HOLD_EN defined: hold_req=1, load words, drop hold_req → cpu_rst_n rises exactly 2 cycles later. Reset asserted mid-ISSUE → all enables 0 immediately.
